// File: rtl/sw_debounce.sv
// Synchronises and debounces WIDTH switch bits plus one enable bit, each on its own independent channel.
// Latency: a raw level held stable from edge k is committed after edge k+DB_CYCLES+1; all outputs are registered.
// No backpressure: each channel consumes one sample per cycle, and sw_changed pulses once for each commit cycle.
module sw_debounce #(
  parameter int WIDTH     = 8,
  parameter int DB_CYCLES = 50000,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic             en_raw,
  output logic [WIDTH-1:0] sw_db,
  output logic             en_db,
  output logic             sw_changed
);

  localparam int N = WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // The enable bit is the top channel, so all channels share one datapath.
  logic [N-1:0]            raw;
  logic [N-1:0]            s1_q, s1_d;
  logic [N-1:0]            s2_q, s2_d;
  logic [N-1:0]            db_q, db_d;
  logic [N-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]            commit;
  logic                    sw_changed_q, sw_changed_d;

  assign raw = {en_raw, sw_raw};

  always_comb begin
    s1_d   = raw;
    s2_d   = s1_q;
    db_d   = db_q;
    cnt_d  = '0;
    commit = '0;
    for (int i = 0; i < N; i++) begin
      // Any sample equal to db leaves cnt_d at zero, so a bounce restarts the full window.
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          db_d[i]   = s2_q[i];
          commit[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
    sw_changed_d = |commit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q         <= '0;
      s2_q         <= '0;
      db_q         <= '0;
      cnt_q        <= '0;
      sw_changed_q <= 1'b0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      db_q         <= db_d;
      cnt_q        <= cnt_d;
      sw_changed_q <= sw_changed_d;
    end
  end

  assign sw_db      = db_q[WIDTH-1:0];
  assign en_db      = db_q[WIDTH];
  assign sw_changed = sw_changed_q;

endmodule
